// File: rtl/alarm_pkg.sv
// alarm_pkg: shared encodings and constants for the alarm clock controller.
//   mode_t      - controller mode, also the value driven on alarm_ctrl.mode
//   DIG_*       - edit_digit index of each BCD digit
//   *_MAX       - wrap limits for the BCD digit editor
//   to_bcd_*    - binary (0..59) to BCD tens/units helpers
//   from_bcd    - BCD tens/units back to binary
package alarm_pkg;

    typedef enum logic [1:0] {
        MODE_RUN       = 2'd0,
        MODE_SET_TIME  = 2'd1,
        MODE_SET_ALARM = 2'd2,
        MODE_RING      = 2'd3
    } mode_t;

    localparam logic [1:0] DIG_H1 = 2'd0;
    localparam logic [1:0] DIG_H0 = 2'd1;
    localparam logic [1:0] DIG_M1 = 2'd2;
    localparam logic [1:0] DIG_M0 = 2'd3;

    localparam logic [3:0] H1_MAX     = 4'd2;
    localparam logic [3:0] H0_MAX     = 4'd9;
    localparam logic [3:0] H0_MAX_20S = 4'd3;   // hour units limit while h1 = 2
    localparam logic [3:0] M1_MAX     = 4'd5;
    localparam logic [3:0] M0_MAX     = 4'd9;

    localparam logic [5:0] HOURS_PER_DAY = 6'd24;
    localparam logic [5:0] MIN_PER_HOUR  = 6'd60;

    function automatic logic [3:0] to_bcd_tens(input logic [5:0] v);
        return 4'(v / 6'd10);
    endfunction

    function automatic logic [3:0] to_bcd_units(input logic [5:0] v);
        return 4'(v % 6'd10);
    endfunction

    function automatic logic [5:0] from_bcd(input logic [3:0] tens, input logic [3:0] units);
        return 6'(tens) * 6'd10 + 6'(units);
    endfunction

endpackage

// File: rtl/alarm_ctrl_time_digit_editor.sv
// time_digit_editor: combinational next-value logic for the HH:MM digit editor.
// Ports:
//   btn_next      - advance the selected digit index (mod 4)
//   btn_up        - increment the selected digit with wrap
//   edit_digit    - currently selected digit index
//   h1/h0/m1/m0   - current BCD digits
//   *_nxt         - digits and index after the press
// The caller resolves button priority; at most one of btn_next/btn_up is high.
module time_digit_editor
    import alarm_pkg::*;
(
    input  logic       btn_next,
    input  logic       btn_up,
    input  logic [1:0] edit_digit,
    input  logic [3:0] h1,
    input  logic [3:0] h0,
    input  logic [3:0] m1,
    input  logic [3:0] m0,
    output logic [1:0] edit_digit_nxt,
    output logic [3:0] h1_nxt,
    output logic [3:0] h0_nxt,
    output logic [3:0] m1_nxt,
    output logic [3:0] m0_nxt
);

    logic [3:0] h0_limit;

    assign h0_limit = (h1 == H1_MAX) ? H0_MAX_20S : H0_MAX;

    always_comb begin
        edit_digit_nxt = edit_digit;
        h1_nxt         = h1;
        h0_nxt         = h0;
        m1_nxt         = m1;
        m0_nxt         = m0;
        if (btn_next) begin
            edit_digit_nxt = edit_digit + 2'd1;
        end else if (btn_up) begin
            case (edit_digit)
                DIG_H1: begin
                    h1_nxt = (h1 >= H1_MAX) ? 4'd0 : h1 + 4'd1;
                    // keep the hour legal when stepping into the 20s
                    if (h1_nxt == H1_MAX && h0 > H0_MAX_20S)
                        h0_nxt = H0_MAX_20S;
                end
                DIG_H0: h0_nxt = (h0 >= h0_limit) ? 4'd0 : h0 + 4'd1;
                DIG_M1: m1_nxt = (m1 >= M1_MAX) ? 4'd0 : m1 + 4'd1;
                default: m0_nxt = (m0 >= M0_MAX) ? 4'd0 : m0 + 4'd1;
            endcase
        end
    end

endmodule

// File: rtl/alarm_ctrl.sv
// alarm_ctrl: user-facing mode controller for the alarm clock.
// Edits BCD digits from debounced buttons, loads the clock datapath through
// set_*/set_pulse, stores the alarm and raises ringing on a per-second match.
// Ports:
//   clk, rst                      - clock, synchronous active-high reset
//   tick                          - 1 Hz one-cycle pulse
//   btn_mode, btn_next, btn_up    - debounced press pulses (mode > next > up)
//   cur_hour/minute/second        - running time, binary
//   set_hour1..set_minute0        - BCD load value, valid with set_pulse
//   alarm_hour/minute, alarm_en   - stored alarm and arm flag
//   ringing, mode, edit_digit     - status for the display
//   blink                         - blink phase of the edited digit
// Optional feature: ALARM_SNOOZE_EN adds snooze on btn_up while ringing.
//
// state          | meaning
// MODE_RUN       | normal clock display, alarm compare active
// MODE_SET_TIME  | editing the time to load into the clock
// MODE_SET_ALARM | editing the stored alarm time
// MODE_RING      | alarm sounding, waiting for dismiss/timeout
module alarm_ctrl
    import alarm_pkg::*;
#(
    parameter int unsigned RING_SEC   = 60,
    parameter int unsigned SNOOZE_MIN = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       btn_mode,
    input  logic       btn_next,
    input  logic       btn_up,
    input  logic [5:0] cur_hour,
    input  logic [5:0] cur_minute,
    input  logic [5:0] cur_second,
    output logic [3:0] set_hour1,
    output logic [3:0] set_hour0,
    output logic [3:0] set_minute1,
    output logic [3:0] set_minute0,
    output logic       set_pulse,
    output logic [5:0] alarm_hour,
    output logic [5:0] alarm_minute,
    output logic       alarm_en,
    output logic       ringing,
    output logic [1:0] mode,
    output logic [1:0] edit_digit,
    output logic       blink
);

    if (RING_SEC < 1 || RING_SEC > 63 || SNOOZE_MIN < 1 || SNOOZE_MIN > 59) begin : g_param_check
        $error("alarm_ctrl: RING_SEC or SNOOZE_MIN out of range");
    end

    mode_t      mode_q, mode_n;
    logic [3:0] h1, h0, m1, m0, h1_n, h0_n, m1_n, m0_n;
    logic [3:0] ed_h1, ed_h0, ed_m1, ed_m0;
    logic [1:0] edit_n, ed_digit;
    logic [3:0] set_h1_n, set_h0_n, set_m1_n, set_m0_n;
    logic       set_pulse_n, alarm_en_n, blink_n;
    logic [5:0] alarm_hour_n, alarm_minute_n;
    logic [5:0] ring_cnt, ring_cnt_n;   // seconds left to ring, counts down
    logic       next_e, up_e, in_set, alarm_hit, snz_hit;

    assign next_e = btn_next & ~btn_mode;
    assign up_e   = btn_up & ~btn_mode & ~btn_next;
    assign in_set = (mode_q == MODE_SET_TIME) || (mode_q == MODE_SET_ALARM);

`ifdef ALARM_SNOOZE_EN
    logic       snz_armed, snz_armed_n;
    logic [5:0] snz_hour, snz_minute, snz_hour_n, snz_minute_n;
    logic [5:0] snz_base_h, snz_base_m, snz_tgt_h, snz_tgt_m;
    logic [6:0] snz_sum;

    assign snz_hit = snz_armed && cur_hour == snz_hour && cur_minute == snz_minute;

    // Repeated snoozes stack on the last snooze target, not the alarm.
    always_comb begin
        snz_base_h = snz_armed ? snz_hour : alarm_hour;
        snz_base_m = snz_armed ? snz_minute : alarm_minute;
        snz_sum    = 7'(snz_base_m) + 7'(SNOOZE_MIN);
        snz_tgt_h  = snz_base_h;
        snz_tgt_m  = 6'(snz_sum);
        if (snz_sum >= 7'(MIN_PER_HOUR)) begin
            snz_tgt_m = 6'(snz_sum - 7'(MIN_PER_HOUR));
            snz_tgt_h = (snz_base_h >= HOURS_PER_DAY - 6'd1) ? 6'd0 : snz_base_h + 6'd1;
        end
    end
`else
    assign snz_hit = 1'b0;
`endif

    assign alarm_hit = alarm_en && tick && cur_second == 6'd0 &&
                       ((cur_hour == alarm_hour && cur_minute == alarm_minute) || snz_hit);

    time_digit_editor u_editor (
        .btn_next       (next_e & in_set),
        .btn_up         (up_e & in_set),
        .edit_digit     (edit_digit),
        .h1             (h1),
        .h0             (h0),
        .m1             (m1),
        .m0             (m0),
        .edit_digit_nxt (ed_digit),
        .h1_nxt         (ed_h1),
        .h0_nxt         (ed_h0),
        .m1_nxt         (ed_m1),
        .m0_nxt         (ed_m0)
    );

    always_comb begin
        mode_n         = mode_q;
        h1_n           = h1;
        h0_n           = h0;
        m1_n           = m1;
        m0_n           = m0;
        edit_n         = edit_digit;
        set_h1_n       = set_hour1;
        set_h0_n       = set_hour0;
        set_m1_n       = set_minute1;
        set_m0_n       = set_minute0;
        set_pulse_n    = 1'b0;
        alarm_hour_n   = alarm_hour;
        alarm_minute_n = alarm_minute;
        alarm_en_n     = alarm_en;
        ring_cnt_n     = ring_cnt;
`ifdef ALARM_SNOOZE_EN
        snz_armed_n    = snz_armed;
        snz_hour_n     = snz_hour;
        snz_minute_n   = snz_minute;
`endif
        case (mode_q)
            MODE_RUN: begin
                if (alarm_hit) begin
                    mode_n     = MODE_RING;
                    ring_cnt_n = 6'(RING_SEC);
                end else if (btn_mode) begin
                    mode_n = MODE_SET_TIME;
                    h1_n   = to_bcd_tens(cur_hour);
                    h0_n   = to_bcd_units(cur_hour);
                    m1_n   = to_bcd_tens(cur_minute);
                    m0_n   = to_bcd_units(cur_minute);
                    edit_n = DIG_H1;
                end
                if (up_e) begin
                    alarm_en_n = ~alarm_en;
`ifdef ALARM_SNOOZE_EN
                    if (alarm_en) snz_armed_n = 1'b0;
`endif
                end
            end
            MODE_SET_TIME: begin
                {h1_n, h0_n, m1_n, m0_n} = {ed_h1, ed_h0, ed_m1, ed_m0};
                edit_n = ed_digit;
                if (btn_mode) begin
                    {set_h1_n, set_h0_n, set_m1_n, set_m0_n} = {h1, h0, m1, m0};
                    set_pulse_n = 1'b1;
                    mode_n      = MODE_SET_ALARM;
                    h1_n        = to_bcd_tens(alarm_hour);
                    h0_n        = to_bcd_units(alarm_hour);
                    m1_n        = to_bcd_tens(alarm_minute);
                    m0_n        = to_bcd_units(alarm_minute);
                    edit_n      = DIG_H1;
                end
            end
            MODE_SET_ALARM: begin
                {h1_n, h0_n, m1_n, m0_n} = {ed_h1, ed_h0, ed_m1, ed_m0};
                edit_n = ed_digit;
                if (btn_mode) begin
                    alarm_hour_n   = from_bcd(h1, h0);
                    alarm_minute_n = from_bcd(m1, m0);
                    mode_n         = MODE_RUN;
                end
            end
            default: begin
                if (btn_mode) begin
                    mode_n = MODE_RUN;
`ifdef ALARM_SNOOZE_EN
                    snz_armed_n = 1'b0;
                end else if (up_e) begin
                    mode_n       = MODE_RUN;
                    snz_armed_n  = 1'b1;
                    snz_hour_n   = snz_tgt_h;
                    snz_minute_n = snz_tgt_m;
`endif
                end else if (tick) begin
                    if (ring_cnt <= 6'd1) begin
                        mode_n = MODE_RUN;
`ifdef ALARM_SNOOZE_EN
                        snz_armed_n = 1'b0;
`endif
                    end else begin
                        ring_cnt_n = ring_cnt - 6'd1;
                    end
                end
            end
        endcase
        if (mode_n == MODE_SET_TIME || mode_n == MODE_SET_ALARM)
            blink_n = tick ? ~blink : blink;
        else
            blink_n = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q       <= MODE_RUN;
            h1           <= 4'd0;
            h0           <= 4'd0;
            m1           <= 4'd0;
            m0           <= 4'd0;
            edit_digit   <= DIG_H1;
            set_hour1    <= 4'd0;
            set_hour0    <= 4'd0;
            set_minute1  <= 4'd0;
            set_minute0  <= 4'd0;
            set_pulse    <= 1'b0;
            alarm_hour   <= 6'd0;
            alarm_minute <= 6'd0;
            alarm_en     <= 1'b0;
            ringing      <= 1'b0;
            blink        <= 1'b0;
            ring_cnt     <= 6'd0;
`ifdef ALARM_SNOOZE_EN
            snz_armed    <= 1'b0;
            snz_hour     <= 6'd0;
            snz_minute   <= 6'd0;
`endif
        end else begin
            mode_q       <= mode_n;
            h1           <= h1_n;
            h0           <= h0_n;
            m1           <= m1_n;
            m0           <= m0_n;
            edit_digit   <= edit_n;
            set_hour1    <= set_h1_n;
            set_hour0    <= set_h0_n;
            set_minute1  <= set_m1_n;
            set_minute0  <= set_m0_n;
            set_pulse    <= set_pulse_n;
            alarm_hour   <= alarm_hour_n;
            alarm_minute <= alarm_minute_n;
            alarm_en     <= alarm_en_n;
            ringing      <= (mode_n == MODE_RING);
            blink        <= blink_n;
            ring_cnt     <= ring_cnt_n;
`ifdef ALARM_SNOOZE_EN
            snz_armed    <= snz_armed_n;
            snz_hour     <= snz_hour_n;
            snz_minute   <= snz_minute_n;
`endif
        end
    end

    assign mode = mode_q;

endmodule

// File: tb/tb_alarm_ctrl.sv
// Self-checking bench for alarm_ctrl: a vector table for the RUN/SET_TIME
// button handling, then hand-written sequences for alarm, ring, timeout,
// dismiss, lost match, reset and (when built with ALARM_SNOOZE_EN) snooze.
module tb_alarm_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0;
    logic       btn_mode = 1'b0, btn_next = 1'b0, btn_up = 1'b0;
    logic [5:0] cur_hour = 6'd0, cur_minute = 6'd0, cur_second = 6'd0;
    logic [3:0] set_hour1, set_hour0, set_minute1, set_minute0;
    logic       set_pulse;
    logic [5:0] alarm_hour, alarm_minute;
    logic       alarm_en, ringing, blink;
    logic [1:0] mode, edit_digit;

    int n_pass = 0;
    int n_total = 0;
    int pulse_count = 0;

    alarm_ctrl #(.RING_SEC(60), .SNOOZE_MIN(5)) dut (
        .clk(clk), .rst(rst), .tick(tick),
        .btn_mode(btn_mode), .btn_next(btn_next), .btn_up(btn_up),
        .cur_hour(cur_hour), .cur_minute(cur_minute), .cur_second(cur_second),
        .set_hour1(set_hour1), .set_hour0(set_hour0),
        .set_minute1(set_minute1), .set_minute0(set_minute0),
        .set_pulse(set_pulse),
        .alarm_hour(alarm_hour), .alarm_minute(alarm_minute),
        .alarm_en(alarm_en), .ringing(ringing), .mode(mode),
        .edit_digit(edit_digit), .blink(blink)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (set_pulse === 1'b1) pulse_count++;

    typedef struct {
        bit       m, n, u, t;
        int       e_mode, e_digit;
        bit       e_en, e_blink, e_pulse;
    } vec_t;

    vec_t tbl[18];

    function automatic vec_t mk(input bit m, n, u, t, input int md, dg,
                                input bit en, bl, pl);
        vec_t v;
        v.m = m; v.n = n; v.u = u; v.t = t;
        v.e_mode = md; v.e_digit = dg;
        v.e_en = en; v.e_blink = bl; v.e_pulse = pl;
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0d expected %0d", name, act, exp);
        else n_pass++;
    endtask

    task automatic cyc(input bit m, n, u, t);
        btn_mode = m; btn_next = n; btn_up = u; tick = t;
        @(posedge clk);
        #1;
        btn_mode = 1'b0; btn_next = 1'b0; btn_up = 1'b0; tick = 1'b0;
    endtask

    task automatic ups(input int k);
        repeat (k) cyc(1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic set_cur(input int h, mi, s);
        cur_hour = 6'(h); cur_minute = 6'(mi); cur_second = 6'(s);
    endtask

    initial begin
        // cur 19:47 -> digits 1,9,4,7
        tbl[0]  = mk(1'b0,1'b0,1'b1,1'b0, 0,0, 1'b1,1'b0,1'b0); // up toggles alarm_en on
        tbl[1]  = mk(1'b0,1'b0,1'b1,1'b0, 0,0, 1'b0,1'b0,1'b0); // and off
        tbl[2]  = mk(1'b0,1'b1,1'b1,1'b0, 0,0, 1'b0,1'b0,1'b0); // next drops up
        tbl[3]  = mk(1'b1,1'b0,1'b1,1'b0, 1,0, 1'b0,1'b0,1'b0); // mode drops up -> SET_TIME
        tbl[4]  = mk(1'b0,1'b0,1'b0,1'b1, 1,0, 1'b0,1'b1,1'b0); // tick blinks
        tbl[5]  = mk(1'b0,1'b0,1'b1,1'b0, 1,0, 1'b0,1'b1,1'b0); // h1 1->2, h0 9 clamps to 3
        tbl[6]  = mk(1'b0,1'b1,1'b0,1'b1, 1,1, 1'b0,1'b0,1'b0); // next + tick both honoured
        tbl[7]  = mk(1'b0,1'b0,1'b1,1'b0, 1,1, 1'b0,1'b0,1'b0); // h0 3->0
        tbl[8]  = mk(1'b0,1'b0,1'b1,1'b0, 1,1, 1'b0,1'b0,1'b0); // 1
        tbl[9]  = mk(1'b0,1'b0,1'b1,1'b0, 1,1, 1'b0,1'b0,1'b0); // 2
        tbl[10] = mk(1'b0,1'b0,1'b1,1'b0, 1,1, 1'b0,1'b0,1'b0); // 3
        tbl[11] = mk(1'b0,1'b0,1'b1,1'b0, 1,1, 1'b0,1'b0,1'b0); // 0
        tbl[12] = mk(1'b0,1'b1,1'b0,1'b0, 1,2, 1'b0,1'b0,1'b0);
        tbl[13] = mk(1'b0,1'b1,1'b0,1'b0, 1,3, 1'b0,1'b0,1'b0);
        tbl[14] = mk(1'b0,1'b1,1'b0,1'b0, 1,0, 1'b0,1'b0,1'b0); // index wraps
        tbl[15] = mk(1'b0,1'b1,1'b0,1'b0, 1,1, 1'b0,1'b0,1'b0);
        tbl[16] = mk(1'b1,1'b0,1'b0,1'b0, 2,0, 1'b0,1'b0,1'b1); // load clock, SET_ALARM
        tbl[17] = mk(1'b0,1'b0,1'b0,1'b0, 2,0, 1'b0,1'b0,1'b0); // pulse is one cycle

        // reset
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_mode", int'(mode), 0);
        check("rst_ringing", int'(ringing), 0);
        check("rst_alarm_en", int'(alarm_en), 0);
        check("rst_set_pulse", int'(set_pulse), 0);
        check("rst_set_digits", int'({set_hour1, set_hour0, set_minute1, set_minute0}), 0);
        check("rst_alarm_time", int'({alarm_hour, alarm_minute}), 0);
        check("rst_edit_digit", int'(edit_digit), 0);
        check("rst_blink", int'(blink), 0);
        repeat (10) cyc(1'b0, 1'b0, 1'b0, 1'b1);
        check("idle_mode", int'(mode), 0);
        check("idle_ringing", int'(ringing), 0);
        check("idle_no_pulse", pulse_count, 0);

        // table: RUN buttons and SET_TIME editing
        set_cur(19, 47, 5);
        for (int i = 0; i < 18; i++) begin
            cyc(tbl[i].m, tbl[i].n, tbl[i].u, tbl[i].t);
            check($sformatf("vec%0d_mode", i), int'(mode), tbl[i].e_mode);
            check($sformatf("vec%0d_digit", i), int'(edit_digit), tbl[i].e_digit);
            check($sformatf("vec%0d_alarm_en", i), int'(alarm_en), int'(tbl[i].e_en));
            check($sformatf("vec%0d_blink", i), int'(blink), int'(tbl[i].e_blink));
            check($sformatf("vec%0d_pulse", i), int'(set_pulse), int'(tbl[i].e_pulse));
            if (i >= 16)
                check($sformatf("vec%0d_set_digits", i),
                      int'({set_hour1, set_hour0, set_minute1, set_minute0}), 'h2047);
        end
        check("pulse_count_1", pulse_count, 1);

        // SET_ALARM 07:30 (digits start from alarm 00:00)
        ups(3);                               // h1 0->1->2->0
        cyc(1'b0, 1'b1, 1'b0, 1'b0); ups(7);  // h0 = 7
        cyc(1'b0, 1'b1, 1'b0, 1'b0); ups(9);  // m1 wraps past 5, ends at 3
        cyc(1'b0, 1'b1, 1'b0, 1'b0); ups(10); // m0 wraps back to 0
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        check("alarm_mode_run", int'(mode), 0);
        check("alarm_hour", int'(alarm_hour), 7);
        check("alarm_minute", int'(alarm_minute), 30);
        ups(1);
        check("alarm_armed", int'(alarm_en), 1);

        // trigger, ignored up (default build), timeout after 60 ticks
        set_cur(7, 30, 0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        check("trig_ringing", int'(ringing), 1);
        check("trig_mode", int'(mode), 3);
        set_cur(7, 30, 1);
`ifndef ALARM_SNOOZE_EN
        ups(1);
        check("ring_up_ignored", int'(ringing), 1);
`endif
        repeat (59) cyc(1'b0, 1'b0, 1'b0, 1'b1);
        check("ring_59_ticks", int'(ringing), 1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        check("timeout_ringing", int'(ringing), 0);
        check("timeout_mode", int'(mode), 0);
        check("timeout_alarm_en", int'(alarm_en), 1);

        // trigger beats mode; dismiss together with the 60th tick
        set_cur(7, 30, 0);
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
        check("trig_beats_mode", int'(mode), 3);
        set_cur(7, 30, 1);
        repeat (59) cyc(1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
        check("dismiss_mode", int'(mode), 0);
        check("dismiss_ringing", int'(ringing), 0);
        check("dismiss_alarm_en", int'(alarm_en), 1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        check("dismiss_stays_run", int'(mode), 0);

        // match while editing is lost
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        set_cur(7, 30, 0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        check("lost_mode", int'(mode), 1);
        check("lost_ringing", int'(ringing), 0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        set_cur(7, 30, 1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        check("lost_no_replay", int'(mode), 0);
        check("lost_alarm_kept", int'({alarm_hour, alarm_minute}), (7 << 6) | 30);
        check("pulse_count_2", pulse_count, 2);

        // reset mid-edit
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        check("rst_edit_mode", int'(mode), 0);
        check("rst_edit_alarm", int'({alarm_hour, alarm_minute}), 0);
        check("rst_edit_en", int'(alarm_en), 0);
        check("rst_edit_no_pulse", pulse_count, 2);

`ifdef ALARM_SNOOZE_EN
        // alarm 23:58, snooze to 00:03, dismiss, nothing at 00:08
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        ups(2);
        cyc(1'b0, 1'b1, 1'b0, 1'b0); ups(3);
        cyc(1'b0, 1'b1, 1'b0, 1'b0); ups(5);
        cyc(1'b0, 1'b1, 1'b0, 1'b0); ups(8);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        check("snz_alarm", int'({alarm_hour, alarm_minute}), (23 << 6) | 58);
        ups(1);
        set_cur(23, 58, 0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        check("snz_first_ring", int'(ringing), 1);
        set_cur(23, 58, 1);
        ups(1);
        check("snz_leave_ring", int'(ringing), 0);
        set_cur(0, 3, 0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        check("snz_re_ring", int'(ringing), 1);
        set_cur(0, 3, 1);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        check("snz_dismiss", int'(mode), 0);
        set_cur(0, 8, 0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        check("snz_disarmed", int'(ringing), 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
